// File: rtl/lfsr_crypt_engine.sv
// lfsr_crypt_engine: streaming LFSR cipher with known-preamble seed/tap recovery.
// Optional define STRIP_PAD_EN drops leading decrypted pad words in search mode.
module lfsr_crypt_engine #(
    parameter int WIDTH      = 8,
    parameter int NUM_PTRN   = 8,
    parameter int SEARCH_LEN = 8,
    parameter int LEN_W      = 7,
    parameter logic [WIDTH-1:0] PAD_CHAR = 8'h20
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        mode,
    input  logic [WIDTH-1:0]            ptrn_in,
    input  logic [WIDTH-1:0]            seed_in,
    input  logic [NUM_PTRN*WIDTH-1:0]   ptrn_tbl,
    input  logic [LEN_W-1:0]            msg_len,
    input  logic                        in_valid,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        done,
    output logic                        found,
    output logic [$clog2(NUM_PTRN)-1:0] ptrn_idx,
    output logic                        err,
    output logic [LEN_W-1:0]            out_count
);
    localparam int IW = $clog2(NUM_PTRN);
    localparam int SW = $clog2(SEARCH_LEN);
    localparam logic [LEN_W-1:0] SLEN  = LEN_W'(SEARCH_LEN);
    localparam logic [SW-1:0]    ILAST = SW'(SEARCH_LEN - 1);
    localparam logic [IW-1:0]    KLAST = IW'(NUM_PTRN - 1);

    typedef enum logic [2:0] {S_IDLE, S_STREAM, S_FILL, S_SEARCH, S_FLUSH, S_DONE} state_t;

    state_t             state, state_n;
    logic [WIDTH-1:0]   s_q, s_n, seed_q, seed_n, ptrn_q, ptrn_n;
    logic [IW-1:0]      k_q, k_n, pidx_n;
    logic [SW-1:0]      idx_q, idx_n;
    logic [LEN_W-1:0]   len_q, len_n, cnt_q, cnt_n, oc_n;
    logic [WIDTH-1:0]   buf_q [SEARCH_LEN];
    logic [WIDTH-1:0]   od_n, cur_ptrn, step, word;
    logic               ov_n, found_n, err_n, slot_free, emit, keep, buf_we;
`ifdef STRIP_PAD_EN
    logic               strip_q, strip_n;
`endif

    // During search the taps come straight from the candidate table entry k.
    always_comb begin
        cur_ptrn = (state == S_SEARCH) ? ptrn_tbl[k_q*WIDTH +: WIDTH] : ptrn_q;
        step     = {s_q[WIDTH-2:0], ^(s_q & cur_ptrn)};
    end

    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);

    always_comb begin
        state_n   = state;
        s_n       = s_q;
        seed_n    = seed_q;
        ptrn_n    = ptrn_q;
        k_n       = k_q;
        idx_n     = idx_q;
        len_n     = len_q;
        cnt_n     = cnt_q;
        found_n   = found;
        err_n     = err;
        pidx_n    = ptrn_idx;
        slot_free = ~out_valid | out_ready;
        ov_n      = out_valid & ~out_ready;
        od_n      = out_data;
        oc_n      = (out_valid && out_ready && out_count != '1) ? out_count + 1'b1 : out_count;
        in_ready  = 1'b0;
        emit      = 1'b0;
        word      = '0;
        buf_we    = 1'b0;
        keep      = 1'b1;
`ifdef STRIP_PAD_EN
        strip_n   = strip_q;
`endif
        case (state)
            S_IDLE, S_DONE: if (start) begin
                len_n   = msg_len;
                cnt_n   = '0;
                idx_n   = '0;
                k_n     = '0;
                found_n = 1'b0;
                err_n   = 1'b0;
                pidx_n  = '0;
                oc_n    = '0;
                s_n     = seed_in;
                ptrn_n  = ptrn_in;
`ifdef STRIP_PAD_EN
                strip_n = mode;
`endif
                if (!mode)
                    state_n = S_STREAM;
                else if (msg_len < SLEN) begin
                    err_n   = 1'b1;
                    state_n = S_DONE;
                end else
                    state_n = S_FILL;
            end
            S_STREAM: begin
                in_ready = slot_free && (cnt_q != len_q);
                if (in_valid && in_ready) begin
                    emit  = 1'b1;
                    word  = in_data ^ s_q;
                    s_n   = step;
                    cnt_n = cnt_q + 1'b1;
                end else if (cnt_q == len_q && slot_free)
                    state_n = S_DONE;
            end
            S_FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    buf_we = 1'b1;
                    cnt_n  = cnt_q + 1'b1;
                    idx_n  = idx_q + 1'b1;
                    if (idx_q == ILAST) begin
                        seed_n  = buf_q[0] ^ PAD_CHAR;
                        s_n     = buf_q[0] ^ PAD_CHAR;
                        k_n     = '0;
                        idx_n   = SW'(1);
                        state_n = S_SEARCH;
                    end
                end
            end
            S_SEARCH: begin
                if ((buf_q[idx_q] ^ step) == PAD_CHAR) begin
                    if (idx_q == ILAST) begin
                        found_n = 1'b1;
                        pidx_n  = k_q;
                        ptrn_n  = cur_ptrn;
                        s_n     = seed_q;
                        idx_n   = '0;
                        state_n = S_FLUSH;
                    end else begin
                        s_n   = step;
                        idx_n = idx_q + 1'b1;
                    end
                end else if (k_q == KLAST) begin
                    err_n   = 1'b1;
                    state_n = S_DONE;
                end else begin
                    k_n   = k_q + 1'b1;
                    s_n   = seed_q;
                    idx_n = SW'(1);
                end
            end
            S_FLUSH: if (slot_free) begin
                emit  = 1'b1;
                word  = buf_q[idx_q] ^ s_q;
                s_n   = step;
                idx_n = idx_q + 1'b1;
                if (idx_q == ILAST)
                    state_n = S_STREAM;
            end
            default: state_n = S_IDLE;
        endcase
`ifdef STRIP_PAD_EN
        // Suppression ends permanently at the first non-pad plaintext word.
        if (emit && strip_q) begin
            if (word == PAD_CHAR) keep = 1'b0;
            else                  strip_n = 1'b0;
        end
`endif
        if (emit && keep) begin
            ov_n = 1'b1;
            od_n = word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            s_q       <= '0;
            seed_q    <= '0;
            ptrn_q    <= '0;
            k_q       <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            found     <= 1'b0;
            err       <= 1'b0;
            ptrn_idx  <= '0;
`ifdef STRIP_PAD_EN
            strip_q   <= 1'b0;
`endif
            for (int j = 0; j < SEARCH_LEN; j++) buf_q[j] <= '0;
        end else begin
            state     <= state_n;
            s_q       <= s_n;
            seed_q    <= seed_n;
            ptrn_q    <= ptrn_n;
            k_q       <= k_n;
            idx_q     <= idx_n;
            len_q     <= len_n;
            cnt_q     <= cnt_n;
            out_valid <= ov_n;
            out_data  <= od_n;
            out_count <= oc_n;
            found     <= found_n;
            err       <= err_n;
            ptrn_idx  <= pidx_n;
`ifdef STRIP_PAD_EN
            strip_q   <= strip_n;
`endif
            if (buf_we) buf_q[idx_q] <= in_data;
        end
    end
endmodule

// File: doc/lfsr_crypt_engine.md
Name: lfsr_crypt_engine

Overview:
Streaming hardware LFSR cipher. It is the parametrised successor to the software encrypt/decrypt programs run on the 9-bit CPU.
- Encrypt/decrypt mode: XORs each data word with a running LFSR state, using a known tap pattern and seed.
- Search mode: recovers the seed and tap pattern from a known pad-character preamble, then decrypts the rest of the message.
- Sits between the data-memory DMA stream and the core as a coprocessor.

Parameters:
WIDTH, 8, data word and LFSR width in bits
NUM_PTRN, 8, number of candidate tap patterns in the search table
SEARCH_LEN, 8, preamble words buffered and checked in search mode (>=2)
LEN_W, 7, width of message length counter
PAD_CHAR, 8'h20, known plaintext preamble value (WIDTH bits)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins an operation; ignored while busy=1
mode  in  1  0 = encrypt/decrypt with ptrn_in and seed_in; 1 = search
ptrn_in  in  WIDTH  tap pattern (mode 0)
seed_in  in  WIDTH  initial LFSR state (mode 0)
ptrn_tbl  in  NUM_PTRN*WIDTH  candidate patterns; entry k = bits [k*WIDTH +: WIDTH]
msg_len  in  LEN_W  total words to consume, sampled at start
in_valid  in  1  input word valid
in_data  in  WIDTH  input word
in_ready  out  1  engine accepts the word this cycle
out_valid  out  1  output word valid
out_data  out  WIDTH  output word
out_ready  in  1  sink accepts the output word
busy  out  1  operation in progress
done  out  1  level; high in DONE until next accepted start
found  out  1  search succeeded
ptrn_idx  out  $clog2(NUM_PTRN)  index of the matching pattern
err  out  1  search failed, or msg_len < SEARCH_LEN in mode 1
out_count  out  LEN_W  number of words emitted

Behaviour:
- Reset: all outputs are 0; state is IDLE; LFSR, buffer and counters are cleared. Reset is honoured in any state and aborts the operation; no partial output remains valid.
- LFSR step: next = {s[WIDTH-2:0], ^(s & ptrn)}. Word i is transformed as out = in ^ s_i, with s_0 = seed.
- Handshakes:
  - An input transfer occurs on in_valid & in_ready; an output transfer on out_valid & out_ready.
  - out_valid and out_data stay stable until accepted.
  - in_ready = 0 whenever the single output register is full and out_ready = 0.
- States:
  - IDLE: on start, latch mode and msg_len, clear flags, set busy=1. Mode 0 goes to STREAM with s = seed_in, ptrn = ptrn_in. Mode 1 goes to FILL; if msg_len < SEARCH_LEN it goes straight to DONE with err=1.
  - STREAM: each accepted input produces an output one cycle later (latency 1, throughput 1 word/cycle without backpressure), then the LFSR steps. Moves to DONE after the msg_len-th input has been consumed and its output accepted.
  - FILL: accepts SEARCH_LEN words into the buffer with in_ready=1 and no output. Then sets seed = buf[0] ^ PAD_CHAR, k = 0, i = 1, and moves to SEARCH.
  - SEARCH: one compare per cycle. Step s, then test buf[i] ^ s == PAD_CHAR.
    - Match with i = SEARCH_LEN-1: found=1, ptrn_idx=k, go to FLUSH.
    - Mismatch: k++, s = seed, i = 1.
    - k wraps past NUM_PTRN-1: err=1, go to DONE.
    - Worst case is NUM_PTRN*(SEARCH_LEN-1) cycles. in_ready = 0 throughout.
  - FLUSH: s reset to seed; emits buf[0..SEARCH_LEN-1] ^ s_i in order with handshake, then enters STREAM for the remaining msg_len - SEARCH_LEN words with the LFSR continuing.
  - DONE: busy=0, done=1; flags held; start returns to IDLE processing.
- The first matching pattern in table order wins.
- Input words beyond msg_len are not accepted.
- out_count saturates at 2^LEN_W - 1.

Optional Feature:
STRIP_PAD_EN
- Defined: in mode 1, leading decrypted words equal to PAD_CHAR are suppressed (not emitted, not counted in out_count) until the first non-pad word; all later words are emitted, including pads. Mode 0 is unaffected. If every word is pad, out_count = 0 and DONE is still reached.
- Undefined: every word is emitted.

Test Plan:
- Mode 0, seed 01, ptrn F3, msg_len 4, input 20 20 20 20 -> output 21 23 26 2D; done=1; out_count=4.
- Mode 1, ptrn_tbl = {E1,D4,C6,B8,B4,B2,FA,F3}, msg_len 16, input = 12 pads plus "ABCD", encrypted with ptrn F3 seed 01 -> found=1, ptrn_idx=7, output 20 x12 then 41 42 43 44.
- Mode 1, all candidate patterns wrong (table lacks the pattern used to encrypt) -> err=1, found=0, no output, done=1.
- Mode 0 with out_ready low for 5 cycles mid-stream -> out_data stable, in_ready=0, no word lost or duplicated; full sequence matches the reference model.
- Assert reset during SEARCH and during STREAM -> all outputs 0 immediately; a subsequent start completes correctly.
- STRIP_PAD_EN defined, same stimulus as scenario 2 -> output 41 42 43 44 only; out_count=4.
